// File: rtl/bp_sched_pkg.sv
// bp_sched_pkg -- shared state encoding, 2-bit counter constants and saturating update.
// Rev 1.0
`default_nettype none

package bp_sched_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_UPD_WR = 2'd2
  } sched_state_t;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST) ? ST : ctr + 2'd1;
    else       return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bp_upd_fifo.sv
// bp_upd_fifo -- small FIFO holding pending predictor updates {index, taken}.
// Rev 1.0
`default_nettype none

module bp_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/bp_table_scheduler.sv
// bp_table_scheduler -- arbitrates one pattern-table port between lookups and queued updates.
// Optional statistics outputs enabled by defining BP_SCHED_STATS_EN. Rev 1.0
`default_nettype none

module bp_table_scheduler
  import bp_sched_pkg::*;
#(
  parameter int IDX_W      = 6,
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lk_valid,
  input  logic [31:0]      lk_pc,
  output logic             lk_ready,
  output logic             lk_resp_valid,
  output logic             lk_pred,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  output logic             upd_ready,
  output logic             tbl_en,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_idx,
  output logic [1:0]       tbl_wdata,
  input  logic [1:0]       tbl_rdata,
  output logic             init_done
`ifdef BP_SCHED_STATS_EN
  ,
  output logic [15:0]      stat_lookups,
  output logic [15:0]      stat_stalls
`endif
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

  sched_state_t     state;
  sched_state_t     state_nxt;
  logic [IDX_W-1:0] init_idx;
  logic [SC_W-1:0]  starve_cnt;
  logic             lk_grant;
  logic             upd_grant;
  logic             q_push;
  logic             q_pop;
  logic             q_empty;
  logic             q_full;
  logic [IDX_W:0]   q_head;
  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             unused_pc_bits;

  assign lk_idx         = lk_pc[IDX_W+1:2];
  assign upd_idx        = upd_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{lk_pc[31:IDX_W+2], lk_pc[1:0], upd_pc[31:IDX_W+2], upd_pc[1:0]};

  assign init_done = (state != ST_INIT);
  assign upd_ready = init_done && !q_full;
  assign q_push    = upd_valid && upd_ready;
  assign lk_ready  = lk_grant;
  assign lk_pred   = lk_resp_valid && tbl_rdata[1];

  bp_upd_fifo #(
    .DEPTH(QDEPTH),
    .WIDTH(IDX_W + 1)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (q_push),
    .push_data({upd_idx, upd_taken}),
    .pop      (q_pop),
    .head     (q_head),
    .empty    (q_empty),
    .full     (q_full)
  );

  always_comb begin
    state_nxt = state;
    tbl_en    = 1'b0;
    tbl_we    = 1'b0;
    tbl_idx   = '0;
    tbl_wdata = WNT;
    lk_grant  = 1'b0;
    upd_grant = 1'b0;
    q_pop     = 1'b0;
    case (state)
      ST_INIT: begin
        // Port stays quiet while reset is held, even though state already reads INIT.
        tbl_en  = !reset;
        tbl_we  = !reset;
        tbl_idx = init_idx;
        if (init_idx == {IDX_W{1'b1}}) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (lk_valid && (q_empty || starve_cnt < STARVE_LIM)) begin
          lk_grant = 1'b1;
          tbl_en   = 1'b1;
          tbl_idx  = lk_idx;
        end else if (!q_empty) begin
          upd_grant = 1'b1;
          tbl_en    = 1'b1;
          tbl_idx   = q_head[IDX_W:1];
          state_nxt = ST_UPD_WR;
        end
      end
      ST_UPD_WR: begin
        tbl_en    = 1'b1;
        tbl_we    = 1'b1;
        tbl_idx   = q_head[IDX_W:1];
        tbl_wdata = sat_update(tbl_rdata, q_head[0]);
        q_pop     = 1'b1;
        state_nxt = ST_RUN;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_INIT;
      init_idx      <= '0;
      starve_cnt    <= '0;
      lk_resp_valid <= 1'b0;
    end else begin
      state         <= state_nxt;
      lk_resp_valid <= lk_grant;
      if (state == ST_INIT) init_idx <= init_idx + 1'b1;
      if (upd_grant)
        starve_cnt <= '0;
      else if (lk_grant && !q_empty && starve_cnt < STARVE_LIM)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

`ifdef BP_SCHED_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_lookups <= '0;
      stat_stalls  <= '0;
    end else begin
      if (lk_grant && stat_lookups != 16'hFFFF) stat_lookups <= stat_lookups + 1'b1;
      if (state == ST_RUN && lk_valid && !lk_grant && stat_stalls != 16'hFFFF)
        stat_stalls <= stat_stalls + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire
